// File: rtl/orgasmall_control_unit.sv
// rtl/orgasmall_control_unit.sv - OrgaSmall multi-cycle sequencer: PC, flags, datapath strobes
// Optional build macro ORGASMALL_SINGLE_STEP_EN adds step/idle single-instruction stepping.
module orgasmall_control_unit #(
  parameter int ADDR_SIZE   = 8,
  parameter int OPCODE_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ORGASMALL_SINGLE_STEP_EN
  input  logic                   step,
  output logic                   idle,
`endif
  input  logic [OPCODE_BITS-1:0] opcode,
  input  logic [ADDR_SIZE-1:0]   imm,
  input  logic                   alu_c,
  input  logic                   alu_z,
  input  logic                   alu_n,
  input  logic                   mem_ack,
  output logic [ADDR_SIZE-1:0]   pc,
  output logic                   ir_load,
  output logic                   reg_we,
  output logic [1:0]             reg_src,
  output logic                   flags_we,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic                   mem_addr_sel,
  output logic                   flag_c,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   halted
);

  localparam logic [OPCODE_BITS-1:0] OP_ADD   = OPCODE_BITS'(5'b00001);
  localparam logic [OPCODE_BITS-1:0] OP_ADC   = OPCODE_BITS'(5'b00010);
  localparam logic [OPCODE_BITS-1:0] OP_SUB   = OPCODE_BITS'(5'b00011);
  localparam logic [OPCODE_BITS-1:0] OP_AND   = OPCODE_BITS'(5'b00100);
  localparam logic [OPCODE_BITS-1:0] OP_OR    = OPCODE_BITS'(5'b00101);
  localparam logic [OPCODE_BITS-1:0] OP_XOR   = OPCODE_BITS'(5'b00110);
  localparam logic [OPCODE_BITS-1:0] OP_CMP   = OPCODE_BITS'(5'b00111);
  localparam logic [OPCODE_BITS-1:0] OP_MOV   = OPCODE_BITS'(5'b01000);
  localparam logic [OPCODE_BITS-1:0] OP_INC   = OPCODE_BITS'(5'b11000);
  localparam logic [OPCODE_BITS-1:0] OP_DEC   = OPCODE_BITS'(5'b11001);
  localparam logic [OPCODE_BITS-1:0] OP_SHR   = OPCODE_BITS'(5'b11010);
  localparam logic [OPCODE_BITS-1:0] OP_SHL   = OPCODE_BITS'(5'b11011);
  localparam logic [OPCODE_BITS-1:0] OP_STR   = OPCODE_BITS'(5'b10000);
  localparam logic [OPCODE_BITS-1:0] OP_LOAD  = OPCODE_BITS'(5'b10001);
  localparam logic [OPCODE_BITS-1:0] OP_RSTR  = OPCODE_BITS'(5'b10010);
  localparam logic [OPCODE_BITS-1:0] OP_RLOAD = OPCODE_BITS'(5'b10011);
  localparam logic [OPCODE_BITS-1:0] OP_JMP   = OPCODE_BITS'(5'b10100);
  localparam logic [OPCODE_BITS-1:0] OP_JC    = OPCODE_BITS'(5'b10101);
  localparam logic [OPCODE_BITS-1:0] OP_JZ    = OPCODE_BITS'(5'b10110);
  localparam logic [OPCODE_BITS-1:0] OP_JN    = OPCODE_BITS'(5'b10111);
  localparam logic [OPCODE_BITS-1:0] OP_SET   = OPCODE_BITS'(5'b11111);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;

  state_t state;
  logic   is_alu, is_mem, is_jump, is_set, is_valid;
  logic   is_store, is_load, is_reg_addr;
  logic   reg_we_q;
  logic   reg_src_imm_q;
  logic   advance;
  logic   load_done;

  always_comb begin
    is_alu  = 1'b0;
    is_mem  = 1'b0;
    is_jump = 1'b0;
    is_set  = 1'b0;
    case (opcode)
      OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_MOV,
      OP_INC, OP_DEC, OP_SHR, OP_SHL:   is_alu  = 1'b1;
      OP_STR, OP_LOAD, OP_RSTR, OP_RLOAD: is_mem  = 1'b1;
      OP_JMP, OP_JC, OP_JZ, OP_JN:      is_jump = 1'b1;
      OP_SET:                           is_set  = 1'b1;
      default: ;
    endcase
  end

  assign is_valid    = is_alu | is_mem | is_jump | is_set;
  assign is_store    = (opcode == OP_STR) | (opcode == OP_RSTR);
  assign is_load     = (opcode == OP_LOAD) | (opcode == OP_RLOAD);
  assign is_reg_addr = (opcode == OP_RSTR) | (opcode == OP_RLOAD);

`ifdef ORGASMALL_SINGLE_STEP_EN
  // Edge-detect step so a long pulse still admits only one instruction.
  logic step_d;
  assign advance = step & ~step_d;
  assign idle    = (state == S_FETCH) & ~advance;
`else
  assign advance = 1'b1;
`endif

  assign ir_load   = (state == S_FETCH) & advance;
  // Load write-back must coincide with the ack cycle, so it cannot be registered.
  assign load_done = (state == S_MEM) & mem_ack & is_load;
  assign reg_we    = reg_we_q | load_done;
  assign reg_src   = load_done ? 2'd2 : (reg_src_imm_q ? 2'd1 : 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_FETCH;
      pc            <= '0;
      flag_c        <= 1'b0;
      flag_z        <= 1'b0;
      flag_n        <= 1'b0;
      halted        <= 1'b0;
      reg_we_q      <= 1'b0;
      reg_src_imm_q <= 1'b0;
      flags_we      <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr_sel  <= 1'b0;
`ifdef ORGASMALL_SINGLE_STEP_EN
      step_d        <= 1'b0;
`endif
    end else begin
`ifdef ORGASMALL_SINGLE_STEP_EN
      step_d        <= step;
`endif
      reg_we_q      <= 1'b0;
      reg_src_imm_q <= 1'b0;
      flags_we      <= 1'b0;
      case (state)
        S_FETCH: if (advance) state <= S_DECODE;
        S_DECODE: begin
          if (!is_valid) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            pc <= pc + ADDR_SIZE'(1);
            if (is_mem) begin
              state        <= S_MEM;
              mem_req      <= 1'b1;
              mem_we       <= is_store;
              mem_addr_sel <= is_reg_addr;
            end else begin
              state         <= S_EXEC;
              reg_we_q      <= (is_alu & (opcode != OP_CMP)) | is_set;
              reg_src_imm_q <= is_set;
              flags_we      <= is_alu & (opcode != OP_MOV);
            end
          end
        end
        S_EXEC: begin
          if (flags_we) begin
            flag_c <= alu_c;
            flag_z <= alu_z;
            flag_n <= alu_n;
          end
          // Conditional jumps test the flags as they stood before this cycle.
          if ((opcode == OP_JMP) || ((opcode == OP_JC) && flag_c) ||
              ((opcode == OP_JZ) && flag_z) || ((opcode == OP_JN) && flag_n))
            pc <= imm;
          state <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            state        <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule
